// File: rtl/median_sort_seq.sv
// median_sort_seq: sequential odd-even transposition sorter for one window
// of N unsigned samples. A window is accepted in IDLE, sorted one phase per
// clock in SORT, and presented with median/min/max in HOLD until consumed.
module median_sort_seq #(
    parameter  int N  = 9,
    parameter  int W  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           in_desc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic [W-1:0]   out_median,
    output logic [W-1:0]   out_min,
    output logic [W-1:0]   out_max,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_PHASE = CW'(N - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_phase;
    logic           r_desc;
    logic [W-1:0]   r_arr     [N];
    logic [W-1:0]   w_arr_nxt [N];
    logic [N*W-1:0] w_arr_flat;
    logic [N*W-1:0] r_out_data;
    logic [W-1:0]   r_median;
    logic [W-1:0]   r_min;
    logic [W-1:0]   r_max;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values and simulation matches the synthesized logic.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, run N phases in SORT, wait for the
    // consumer in HOLD.
    always_comb begin
        // NOTE: defaulting to the current state first means no path leaves
        // w_state_nxt unassigned, so no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = S_SORT;
            S_SORT: if (r_phase == LAST_PHASE) w_state_nxt = S_HOLD;
            S_HOLD: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One compare-swap phase: even phases pair (0,1),(2,3)..., odd phases
    // pair (1,2),(3,4)... Pairs are disjoint, so all swaps run in parallel.
    // Equal samples never swap.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_arr_nxt[i] = r_arr[i];
        end
        for (int i = 0; i < N - 1; i++) begin
            if ((i % 2) == int'(r_phase[0])) begin
                if (r_desc ? (r_arr[i] < r_arr[i+1]) : (r_arr[i] > r_arr[i+1])) begin
                    w_arr_nxt[i]   = r_arr[i+1];
                    w_arr_nxt[i+1] = r_arr[i];
                end
            end
        end
    end

    // Flatten the post-phase array for the output register.
    always_comb begin
        w_arr_flat = '0;
        for (int k = 0; k < N; k++) begin
            w_arr_flat[k*W +: W] = w_arr_nxt[k];
        end
    end

    // Datapath: load on acceptance, apply a phase per SORT cycle, capture
    // the final phase into the output registers on the SORT->HOLD edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= '0;
            r_desc     <= 1'b0;
            // NOTE: the working array is reset explicitly (not left to power-up
            // state) so an aborted window can never leak into a later result.
            for (int k = 0; k < N; k++) begin
                r_arr[k] <= '0;
            end
            r_out_data <= '0;
            r_median   <= '0;
            r_min      <= '0;
            r_max      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < N; k++) begin
                            r_arr[k] <= in_data[k*W +: W];
                        end
                        r_desc  <= in_desc;
                        r_phase <= '0;
                    end
                end
                S_SORT: begin
                    for (int k = 0; k < N; k++) begin
                        r_arr[k] <= w_arr_nxt[k];
                    end
                    r_phase <= r_phase + CW'(1);
                    if (r_phase == LAST_PHASE) begin
                        r_out_data <= w_arr_flat;
                        r_median   <= w_arr_nxt[(N-1)/2];
                        r_min      <= r_desc ? w_arr_nxt[N-1] : w_arr_nxt[0];
                        r_max      <= r_desc ? w_arr_nxt[0]   : w_arr_nxt[N-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE) && !reset;
    assign out_valid  = (r_state == S_HOLD);
    assign busy       = (r_state != S_IDLE);
    assign out_data   = r_out_data;
    assign out_median = r_median;
    assign out_min    = r_min;
    assign out_max    = r_max;

endmodule

// File: tb/tb_median_sort_seq.sv
// Directed testbench for median_sort_seq: N=9/W=8 main instance plus
// N=3/W=4 and N=25/W=12 instances sharing clock, reset and input bus.
module tb_median_sort_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   in_valid_v;
    logic [299:0] in_bus;
    logic         in_desc;
    logic         out_ready;

    logic [2:0]   in_ready_v;
    logic [2:0]   out_valid_v;
    logic [2:0]   busy_v;

    logic [71:0]  od9;
    logic [7:0]   om9, omn9, omx9;
    logic [11:0]  od3;
    logic [3:0]   om3, omn3, omx3;
    logic [299:0] od25;
    logic [11:0]  om25, omn25, omx25;

    logic [299:0] od  [3];
    logic [11:0]  om  [3];
    logic [11:0]  omn [3];
    logic [11:0]  omx [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    median_sort_seq #(.N(9), .W(8)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_data(in_bus[71:0]), .in_desc(in_desc),
        .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_data(od9), .out_median(om9), .out_min(omn9), .out_max(omx9),
        .busy(busy_v[0])
    );

    median_sort_seq #(.N(3), .W(4)) u_dut_n3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_data(in_bus[11:0]), .in_desc(in_desc),
        .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_data(od3), .out_median(om3), .out_min(omn3), .out_max(omx3),
        .busy(busy_v[1])
    );

    median_sort_seq #(.N(25), .W(12)) u_dut_n25 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_data(in_bus), .in_desc(in_desc),
        .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_data(od25), .out_median(om25), .out_min(omn25), .out_max(omx25),
        .busy(busy_v[2])
    );

    assign od[0]  = 300'(od9);
    assign od[1]  = 300'(od3);
    assign od[2]  = od25;
    assign om[0]  = 12'(om9);
    assign om[1]  = 12'(om3);
    assign om[2]  = om25;
    assign omn[0] = 12'(omn9);
    assign omn[1] = 12'(omn3);
    assign omn[2] = omn25;
    assign omx[0] = 12'(omx9);
    assign omx[1] = 12'(omx3);
    assign omx[2] = omx25;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pack a list of sample values, w bits each, position 0 in the LSBs.
    function automatic logic [299:0] pk(input int w, input int q[$]);
        logic [299:0] r;
        r = '0;
        foreach (q[k]) r = r | (300'(q[k]) << (k * w));
        return r;
    endfunction

    task automatic send(input int d, input string tag, input logic [299:0] data, input logic desc);
        int guard = 0;
        while (!in_ready_v[d] && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_ready"}, 300'(in_ready_v[d]), 300'(1));
        in_bus        = data;
        in_desc       = desc;
        in_valid_v[d] = 1'b1;
        tick();
        in_valid_v[d] = 1'b0;
        in_bus        = ~data;
        in_desc       = ~desc;
    endtask

    task automatic await_result(input int d, input int n, input string tag);
        int cyc = 0;
        while (!out_valid_v[d] && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 300'(cyc), 300'(n));
    endtask

    task automatic check_out(input int d, input string tag, input logic [299:0] exp,
                             input logic [11:0] med, input logic [11:0] mn, input logic [11:0] mx);
        check({tag, "_valid"},  300'(out_valid_v[d]), 300'(1));
        check({tag, "_data"},   od[d], exp);
        check({tag, "_median"}, 300'(om[d]), 300'(med));
        check({tag, "_min"},    300'(omn[d]), 300'(mn));
        check({tag, "_max"},    300'(omx[d]), 300'(mx));
    endtask

    task automatic release_out(input int d, input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, 300'(out_valid_v[d]), 300'(0));
        check({tag, "_rel_ready"}, 300'(in_ready_v[d]), 300'(1));
        check({tag, "_rel_busy"},  300'(busy_v[d]), 300'(0));
    endtask

    task automatic run(input int d, input int n, input string tag, input logic [299:0] data,
                       input logic desc, input logic [299:0] exp,
                       input logic [11:0] med, input logic [11:0] mn, input logic [11:0] mx);
        send(d, tag, data, desc);
        await_result(d, n, tag);
        check_out(d, tag, exp, med, mn, mx);
        release_out(d, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            v[$];
        logic [299:0]  d_a, e_a, d_b, e_b;
        logic [299:0]  bb_data [3];
        logic [299:0]  bb_exp  [3];
        logic          bb_desc [3];
        logic [11:0]   bb_med  [3];
        logic [11:0]   bb_min  [3];
        logic [11:0]   bb_max  [3];

        reset      = 1'b1;
        in_valid_v = '0;
        in_bus     = '0;
        in_desc    = 1'b0;
        out_ready  = 1'b0;

        // Reset state.
        tick();
        check("rst_in_ready",  300'(in_ready_v), 300'(0));
        check("rst_out_valid", 300'(out_valid_v), 300'(0));
        check("rst_busy",      300'(busy_v), 300'(0));
        check("rst_out_data",  od[0], 300'(0));
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 300'(in_ready_v), 300'(7));

        // Ascending, then descending on the same window.
        v = '{9, 3, 7, 1, 8, 2, 6, 4, 5};  d_a = pk(8, v);
        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};  e_a = pk(8, v);
        run(0, 9, "asc", d_a, 1'b0, e_a, 12'd5, 12'd1, 12'd9);
        v = '{9, 8, 7, 6, 5, 4, 3, 2, 1};  e_b = pk(8, v);
        run(0, 9, "desc", d_a, 1'b1, e_b, 12'd5, 12'd1, 12'd9);

        // Duplicates and extremes, then backpressure while held.
        v = '{255, 0, 255, 0, 128, 128, 0, 255, 128};  d_b = pk(8, v);
        v = '{0, 0, 0, 128, 128, 128, 255, 255, 255};  e_b = pk(8, v);
        send(0, "dup", d_b, 1'b0);
        await_result(0, 9, "dup");
        check_out(0, "dup", e_b, 12'd128, 12'd0, 12'd255);
        for (int i = 0; i < 20; i++) begin
            in_valid_v[0] = (i % 2 == 0);
            for (int j = 0; j < 10; j++) in_bus[j*30 +: 30] = 30'($urandom());
            in_desc = 1'($urandom());
            tick();
            check("bp_data",     od[0], e_b);
            check("bp_median",   300'(om[0]), 300'(128));
            check("bp_valid",    300'(out_valid_v[0]), 300'(1));
            check("bp_in_ready", 300'(in_ready_v[0]), 300'(0));
        end
        in_valid_v[0] = 1'b0;
        release_out(0, "bp");
        check("bp_hold_idle", od[0], e_b);

        // Reset four phases into SORT aborts the window.
        v = '{200, 100, 50, 25, 12, 6, 3, 1, 0};  d_a = pk(8, v);
        send(0, "abort", d_a, 1'b0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("abort_valid",    300'(out_valid_v[0]), 300'(0));
        check("abort_in_ready", 300'(in_ready_v[0]), 300'(0));
        check("abort_busy",     300'(busy_v[0]), 300'(0));
        check("abort_data",     od[0], 300'(0));
        check("abort_median",   300'(om[0]), 300'(0));
        check("abort_min",      300'(omn[0]), 300'(0));
        check("abort_max",      300'(omx[0]), 300'(0));
        tick();
        check("abort_in_ready2", 300'(in_ready_v[0]), 300'(0));
        reset = 1'b0;
        #1;
        v = '{5, 4, 3, 2, 1, 9, 8, 7, 6};  d_a = pk(8, v);
        run(0, 9, "after_rst", d_a, 1'b0, e_a, 12'd5, 12'd1, 12'd9);

        // Back-to-back windows, in_valid and out_ready held high.
        v = '{2, 7, 1, 8, 2, 8, 1, 8, 2};            bb_data[0] = pk(8, v);
        v = '{1, 1, 2, 2, 2, 7, 8, 8, 8};            bb_exp[0]  = pk(8, v);
        bb_desc[0] = 1'b0; bb_med[0] = 12'd2;  bb_min[0] = 12'd1;  bb_max[0] = 12'd8;
        v = '{10, 20, 30, 40, 50, 60, 70, 80, 90};   bb_data[1] = pk(8, v);
        v = '{90, 80, 70, 60, 50, 40, 30, 20, 10};   bb_exp[1]  = pk(8, v);
        bb_desc[1] = 1'b1; bb_med[1] = 12'd50; bb_min[1] = 12'd10; bb_max[1] = 12'd90;
        v = '{3, 3, 3, 3, 3, 3, 3, 3, 3};            bb_data[2] = pk(8, v);
        bb_exp[2]  = bb_data[2];
        bb_desc[2] = 1'b0; bb_med[2] = 12'd3;  bb_min[2] = 12'd3;  bb_max[2] = 12'd3;

        out_ready     = 1'b1;
        in_valid_v[0] = 1'b1;
        in_bus        = bb_data[0];
        in_desc       = bb_desc[0];
        tick();
        for (int w = 0; w < 3; w++) begin
            if (w < 2) begin
                in_bus  = bb_data[w+1];
                in_desc = bb_desc[w+1];
            end else begin
                in_valid_v[0] = 1'b0;
                in_bus        = '0;
            end
            await_result(0, 9, "b2b");
            check_out(0, "b2b", bb_exp[w], bb_med[w], bb_min[w], bb_max[w]);
            tick();
            check("b2b_c10_valid", 300'(out_valid_v[0]), 300'(0));
            check("b2b_c10_ready", 300'(in_ready_v[0]), 300'(1));
            tick();
            check("b2b_c11_busy", 300'(busy_v[0]), 300'(w < 2));
        end
        out_ready = 1'b0;

        // N=3, W=4.
        v = '{15, 0, 7};  d_a = pk(4, v);
        v = '{0, 7, 15};  e_a = pk(4, v);
        run(1, 3, "n3_asc", d_a, 1'b0, e_a, 12'd7, 12'd0, 12'd15);
        v = '{4, 9, 4};   d_a = pk(4, v);
        v = '{9, 4, 4};   e_a = pk(4, v);
        run(1, 3, "n3_desc", d_a, 1'b1, e_a, 12'd4, 12'd4, 12'd9);

        // N=25, W=12: reversed ramp of multiples of 150.
        v = {};
        for (int k = 0; k < 25; k++) v.push_back((25 - k) * 150);
        d_a = pk(12, v);
        v = {};
        for (int k = 0; k < 25; k++) v.push_back((k + 1) * 150);
        e_a = pk(12, v);
        run(2, 25, "n25_asc", d_a, 1'b0, e_a, 12'd1950, 12'd150, 12'd3750);
        run(2, 25, "n25_desc", d_a, 1'b1, d_a, 12'd1950, 12'd150, 12'd3750);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
